// File: rtl/tdp_ram.sv
// -----------------------------------------------------------------------------
// tdp_ram
// True dual-port synchronous RAM with byte-wise write enables, a post-reset
// clear sequencer, optional output register and per-port read-valid flags.
// Same-address A/B writes are flagged on o_collision and resolved with port B
// winning on the bytes both ports enable.
//
// Optional feature macro: TDP_RAM_BYPASS_EN
//   defined   : a read on one port to the address the other port writes in the
//               same cycle returns the merged new word.
//   undefined : that read returns the old word; no forwarding logic is built.
//
// Parameters
//   DATA_W   data width (multiple of 8)
//   ADDR_W   address width, DEPTH = 2**ADDR_W
//   OUT_REG  0: 1-cycle read latency, 1: 2-cycle read latency
//   INIT_VAL word written to every location by the clear sweep
//   KEY      constant driven on o_key_access
//
// Ports
//   i_clk                  sole clock, rising edge
//   i_rst_n                asynchronous active-low reset
//   i_a_we / i_b_we        write request
//   i_a_be / i_b_be        byte enables, bit i qualifies byte i
//   i_a_re / i_b_re        read request
//   i_a_addr / i_b_addr    word address
//   i_a_wdata / i_b_wdata  write data
//   o_a_rdata / o_b_rdata  read data (held while no read completes)
//   o_a_rvalid / o_b_rvalid read data valid this cycle
//   o_init_done            clear sweep complete, ports live
//   o_collision            one-cycle pulse after a same-address A/B write
//   o_key_access           constant KEY
// -----------------------------------------------------------------------------
module tdp_ram #(
  parameter int                 DATA_W   = 32,
  parameter int                 ADDR_W   = 10,
  parameter int                 OUT_REG  = 0,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0,
  parameter logic [15:0]        KEY      = 16'h0032
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_a_we,
  input  logic [DATA_W/8-1:0] i_a_be,
  input  logic              i_a_re,
  input  logic [ADDR_W-1:0] i_a_addr,
  input  logic [DATA_W-1:0] i_a_wdata,
  output logic [DATA_W-1:0] o_a_rdata,
  output logic              o_a_rvalid,
  input  logic              i_b_we,
  input  logic [DATA_W/8-1:0] i_b_be,
  input  logic              i_b_re,
  input  logic [ADDR_W-1:0] i_b_addr,
  input  logic [DATA_W-1:0] i_b_wdata,
  output logic [DATA_W-1:0] o_b_rdata,
  output logic              o_b_rvalid,
  output logic              o_init_done,
  output logic              o_collision,
  output logic [15:0]       o_key_access
);

  localparam int DEPTH  = 1 << ADDR_W;
  localparam int NBYTES = DATA_W / 8;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  // ---------------------------------------------------------------------------
  // Clear sequencer
  // ---------------------------------------------------------------------------
  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_ptr;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_INIT;
      r_ptr   <= '0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_INIT) begin
        r_ptr <= r_ptr + ADDR_W'(1);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_INIT:  if (r_ptr == LAST_ADDR) w_state_next = S_RUN;
      S_RUN:   w_state_next = S_RUN;
      default: w_state_next = S_INIT;
    endcase
  end

  logic w_run;
  assign w_run       = (r_state == S_RUN);
  assign o_init_done = w_run;
  assign o_key_access = KEY;

  // ---------------------------------------------------------------------------
  // Request qualification: every port request is dropped during the sweep.
  // ---------------------------------------------------------------------------
  logic w_a_wr;
  logic w_b_wr;
  logic w_same_addr;
  logic [1:0] w_rd;

  assign w_a_wr      = w_run & i_a_we;
  assign w_b_wr      = w_run & i_b_we;
  assign w_rd[0]     = w_run & i_a_re;
  assign w_rd[1]     = w_run & i_b_re;
  assign w_same_addr = (i_a_addr == i_b_addr);

  // ---------------------------------------------------------------------------
  // Storage. Never reset; only the sweep initialises it. Port B's byte writes
  // are issued after port A's, so on a shared address and byte B wins.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge i_clk) begin
    if (!w_run) begin
      r_mem[r_ptr] <= INIT_VAL;
    end else begin
      for (int i = 0; i < NBYTES; i++) begin
        if (w_a_wr && i_a_be[i]) begin
          r_mem[i_a_addr][8*i +: 8] <= i_a_wdata[8*i +: 8];
        end
        if (w_b_wr && i_b_be[i]) begin
          r_mem[i_b_addr][8*i +: 8] <= i_b_wdata[8*i +: 8];
        end
      end
    end
  end

  // Pre-edge contents at each port's address (read-first).
  logic [DATA_W-1:0] w_a_old;
  logic [DATA_W-1:0] w_b_old;
  assign w_a_old = r_mem[i_a_addr];
  assign w_b_old = r_mem[i_b_addr];

  // Word captured by each port's read stage.
  logic [DATA_W-1:0] w_rd_word [2];

`ifdef TDP_RAM_BYPASS_EN
  // Overlay the enabled bytes of data onto old.
  function automatic logic [DATA_W-1:0] f_merge(
    input logic [DATA_W-1:0] old_word,
    input logic [DATA_W-1:0] new_word,
    input logic [NBYTES-1:0] be
  );
    logic [DATA_W-1:0] res;
    res = old_word;
    for (int i = 0; i < NBYTES; i++) begin
      if (be[i]) res[8*i +: 8] = new_word[8*i +: 8];
    end
    return res;
  endfunction

  // Word that the array will hold at the shared address after this edge when
  // both ports write it: A's bytes first, then B's on top.
  logic [DATA_W-1:0] w_both_word;
  assign w_both_word = f_merge(f_merge(w_a_old, i_a_wdata, i_a_be), i_b_wdata, i_b_be);

  always_comb begin
    w_rd_word[0] = w_a_old;
    w_rd_word[1] = w_b_old;
    if (w_same_addr) begin
      // Forward only when the *other* port writes; a port's own write alone
      // keeps read-first behaviour.
      if (w_b_wr) begin
        w_rd_word[0] = w_a_wr ? w_both_word : f_merge(w_a_old, i_b_wdata, i_b_be);
      end
      if (w_a_wr) begin
        w_rd_word[1] = w_b_wr ? w_both_word : f_merge(w_b_old, i_a_wdata, i_a_be);
      end
    end
  end
`else
  assign w_rd_word[0] = w_a_old;
  assign w_rd_word[1] = w_b_old;
`endif

  // ---------------------------------------------------------------------------
  // Collision flag, registered: high during the cycle after the shared write.
  // ---------------------------------------------------------------------------
  logic r_collision;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_collision <= 1'b0;
    end else begin
      r_collision <= w_a_wr & w_b_wr & w_same_addr;
    end
  end

  assign o_collision = r_collision;

  // ---------------------------------------------------------------------------
  // Per-port read pipeline (index 0 = port A, 1 = port B). Data registers
  // only load when a read completes, so rdata holds between reads.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] w_out_data [2];
  logic [1:0]        w_out_valid;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [DATA_W-1:0] r_rdata;
      logic              r_rvalid;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_rdata  <= '0;
          r_rvalid <= 1'b0;
        end else begin
          r_rvalid <= w_rd[gi];
          if (w_rd[gi]) begin
            r_rdata <= w_rd_word[gi];
          end
        end
      end

      if (OUT_REG != 0) begin : g_oreg
        logic [DATA_W-1:0] r_rdata_q;
        logic              r_rvalid_q;

        always_ff @(posedge i_clk or negedge i_rst_n) begin
          if (!i_rst_n) begin
            r_rdata_q  <= '0;
            r_rvalid_q <= 1'b0;
          end else begin
            r_rvalid_q <= r_rvalid;
            if (r_rvalid) begin
              r_rdata_q <= r_rdata;
            end
          end
        end

        assign w_out_data[gi]  = r_rdata_q;
        assign w_out_valid[gi] = r_rvalid_q;
      end else begin : g_noreg
        assign w_out_data[gi]  = r_rdata;
        assign w_out_valid[gi] = r_rvalid;
      end
    end
  endgenerate

  assign o_a_rdata  = w_out_data[0];
  assign o_b_rdata  = w_out_data[1];
  assign o_a_rvalid = w_out_valid[0];
  assign o_b_rvalid = w_out_valid[1];

endmodule
